key_debounce: RTL and testbench

Debounces and edge-detects the elevator panel's raw push-button inputs (floor calls, door open/close). Runs on the 100 MHz system clock. Paces its filtering from the divider's 380 Hz output, which it receives as an ordinary data input and converts into a one-cycle tick enable. Delivers clean levels plus one-cycle press, release and long-press pulses to the request-latch and control FSM downstream.

---
 rtl/elevator_pkg.sv | 12 +
 rtl/key_debounce_fsm.sv | 111 +++++++++++
 rtl/key_debounce.sv | 51 +++++
 tb/tb_key_debounce.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator panel logic.
// Per-key debounce state encoding, used by key_debounce_fsm.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_debounce_fsm.sv
// One button: 2-flop synchronizer, tick-paced debounce FSM, hold timer and
// registered level/press/release/hold outputs.
//
// state      | meaning
// IDLE       | released and stable, level 0
// DB_PRESS   | key seen high, counting agreeing ticks, level 0
// PRESSED    | press accepted, hold timer running, level 1
// DB_RELEASE | key seen low, counting agreeing ticks, level 1
module key_debounce_fsm
  import elevator_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 380
) (
  input  logic clk100mhz,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int CNT_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int HCNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_TICKS);
  localparam logic [HCNT_W-1:0] HCNT_PRE = HCNT_W'(HOLD_TICKS - 1);

  logic [1:0]        r_sync;
  key_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [HCNT_W-1:0] r_hcnt;
  logic              r_level;
  logic              r_press;
  logic              r_release;
  logic              r_hold;
  logic              w_key;

  assign w_key = r_sync[1];

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_raw};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
      if (i_tick) begin
        unique case (r_state)
          IDLE: begin
            if (w_key) begin
              r_state <= DB_PRESS;
              r_cnt   <= CNT_ONE;
            end
          end
          DB_PRESS: begin
            if (!w_key) begin
              r_state <= IDLE;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= PRESSED;
              r_hcnt  <= '0;
              r_press <= 1'b1;
              r_level <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!w_key) begin
              r_state <= DB_RELEASE;
              r_cnt   <= CNT_ONE;
            end else if (r_hcnt < HCNT_MAX) begin
              r_hcnt <= r_hcnt + 1'b1;
              r_hold <= (r_hcnt == HCNT_PRE);
            end
          end
          DB_RELEASE: begin
            // hcnt is left alone so a release bounce does not restart hold timing
            if (w_key) begin
              r_state <= PRESSED;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= IDLE;
              r_release <= 1'b1;
              r_level   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;

endmodule

// File: rtl/key_debounce.sv
// Panel button debouncer: turns the divider's 380 Hz square wave into a shared
// one-cycle tick and runs one independent debounce FSM per key.
module key_debounce #(
  parameter int N_KEYS       = 8,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 380
) (
  input  logic              clk100mhz,
  input  logic              rst_n,
  input  logic              tick_src,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic [N_KEYS-1:0] keys_hold
);

  logic [1:0] r_tick_sync;
  logic       r_tick_prev;
  logic       r_tick;

  // tick_src is data from another domain: synchronize, then register the rising edge
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_sync <= '0;
      r_tick_prev <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_tick_sync <= {r_tick_sync[0], tick_src};
      r_tick_prev <= r_tick_sync[1];
      r_tick      <= r_tick_sync[1] & ~r_tick_prev;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_fsm (
      .clk100mhz(clk100mhz),
      .rst_n    (rst_n),
      .i_tick   (r_tick),
      .i_key_raw(keys_raw[g]),
      .o_level  (keys_level[g]),
      .o_press  (keys_press[g]),
      .o_release(keys_release[g]),
      .o_hold   (keys_hold[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed key patterns paced by a 20-cycle tick_src;
// expected pulses are queued with their tick number and checked by a monitor.
module tb_key_debounce;

  localparam int N = 8;

  logic         clk100mhz = 1'b0;
  logic         rst_n     = 1'b0;
  logic         tick_src  = 1'b0;
  logic [N-1:0] keys_raw  = '0;
  logic [N-1:0] keys_level, keys_press, keys_release, keys_hold;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_no  = 0;

  typedef struct {
    string      name;
    logic [7:0] press;
    logic [7:0] rel;
    logic [7:0] hold;
    logic [7:0] level;
    int         tick;
  } exp_t;

  exp_t q[$];

  key_debounce #(
    .N_KEYS      (N),
    .STABLE_TICKS(4),
    .HOLD_TICKS  (8)
  ) dut (
    .clk100mhz   (clk100mhz),
    .rst_n       (rst_n),
    .tick_src    (tick_src),
    .keys_raw    (keys_raw),
    .keys_level  (keys_level),
    .keys_press  (keys_press),
    .keys_release(keys_release),
    .keys_hold   (keys_hold)
  );

  always #5 clk100mhz = ~clk100mhz;

  // tick_src: high for phases 0-9, low for 10-19; tick_no counts its rises
  always @(negedge clk100mhz) begin
    cyc = cyc + 1;
    if (!tick_src && (cyc % 20) < 10) tick_no = tick_no + 1;
    tick_src = (cyc % 20) < 10;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_phase(input int p);
    do begin
      @(negedge clk100mhz);
      #2;
    end while ((cyc % 20) != p);
  endtask

  // value set mid low-phase is what the DUT samples on tick number t
  task automatic drive(input logic [7:0] m, output int t);
    wait_phase(10);
    keys_raw = m;
    t = tick_no + 1;
  endtask

  task automatic hold_for(input logic [7:0] m, input int n);
    int t;
    repeat (n) drive(m, t);
  endtask

  task automatic expect_ev(input string nm, input logic [7:0] p, input logic [7:0] r,
                           input logic [7:0] h, input logic [7:0] lvl, input int t);
    exp_t e;
    e.name = nm; e.press = p; e.rel = r; e.hold = h; e.level = lvl; e.tick = t;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk100mhz);
      #1;
      if ((keys_press | keys_release | keys_hold) != '0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual press=%h release=%h hold=%h required none tick=%0d",
                   keys_press, keys_release, keys_hold, tick_no);
        end else begin
          e = q.pop_front();
          chk({e.name, "_press"},   int'(keys_press),   int'(e.press));
          chk({e.name, "_release"}, int'(keys_release), int'(e.rel));
          chk({e.name, "_hold"},    int'(keys_hold),    int'(e.hold));
          chk({e.name, "_level"},   int'(keys_level),   int'(e.level));
          chk({e.name, "_tick"},    tick_no,            e.tick);
        end
      end
    end
  end

  initial begin
    int t0;
    int t;
    repeat (3) @(negedge clk100mhz);
    #2;
    chk("rst_level",   int'(keys_level),   0);
    chk("rst_press",   int'(keys_press),   0);
    chk("rst_release", int'(keys_release), 0);
    chk("rst_hold",    int'(keys_hold),    0);
    wait_phase(14);
    rst_n = 1'b1;

    // clean press, then long press: hold 8 ticks after press, none in 20 more
    drive(8'h01, t0);
    expect_ev("clean_press", 8'h01, 8'h00, 8'h00, 8'h01, t0 + 3);
    expect_ev("long_hold",   8'h00, 8'h00, 8'h01, 8'h01, t0 + 11);
    hold_for(8'h01, 31);

    // release with bounce: low 2, high 1, low 4
    drive(8'h00, t0);
    expect_ev("bounce_release", 8'h00, 8'h01, 8'h00, 8'h00, t0 + 6);
    drive(8'h00, t);
    drive(8'h01, t);
    hold_for(8'h00, 4);

    // bounce press: high 2, low 1, high 4; then a release bounce must not restart hold
    drive(8'h01, t0);
    expect_ev("bounce_press", 8'h01, 8'h00, 8'h00, 8'h01, t0 + 6);
    expect_ev("hold_after_rel_bounce", 8'h00, 8'h00, 8'h01, 8'h01, t0 + 16);
    drive(8'h01, t);
    drive(8'h00, t);
    hold_for(8'h01, 7);
    drive(8'h00, t);
    hold_for(8'h01, 6);
    drive(8'h00, t0);
    expect_ev("clean_release", 8'h00, 8'h01, 8'h00, 8'h00, t0 + 3);
    hold_for(8'h00, 3);

    // concurrency on keys 0, 3, 7
    drive(8'h89, t0);
    expect_ev("multi_press", 8'h89, 8'h00, 8'h00, 8'h89, t0 + 3);
    hold_for(8'h89, 3);
    drive(8'h00, t0);
    expect_ev("multi_release", 8'h00, 8'h89, 8'h00, 8'h00, t0 + 3);
    hold_for(8'h00, 3);

    // reset while key0 is PRESSED, then a fresh press with the key still high
    drive(8'h01, t0);
    expect_ev("pre_reset_press", 8'h01, 8'h00, 8'h00, 8'h01, t0 + 3);
    hold_for(8'h01, 5);
    wait_phase(13);
    rst_n = 1'b0;
    #1;
    chk("midrst_level",   int'(keys_level),   0);
    chk("midrst_press",   int'(keys_press),   0);
    chk("midrst_release", int'(keys_release), 0);
    chk("midrst_hold",    int'(keys_hold),    0);
    wait_phase(15);
    rst_n = 1'b1;
    expect_ev("post_reset_press", 8'h01, 8'h00, 8'h00, 8'h01, tick_no + 4);
    repeat (100) @(negedge clk100mhz);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
